knn_vote: RTL and testbench

Majority-vote classifier that sits directly downstream of one `pipeline_sorter` solver. When the sorter finishes, this block walks the solver's HW_K nearest-neighbour slots through the sorter's `SEL`/`DATA_OUT` read port and builds a per-class label histogram. It then scans the histogram and emits the winning class with a one-cycle `done` pulse. The block is instantiated once per solver, or once behind the solver mux.

---
 rtl/knn_pkg.sv | 20 ++
 rtl/knn_label_hist.sv | 51 +++++
 rtl/knn_vote.sv | 135 +++++++++++++
 tb/tb_knn_vote.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and constants for the k-NN majority vote block.
// No logic here; state encoding, default widths and counter-width helper.
// Consumers: knn_vote, knn_label_hist.
package knn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    localparam int LABEL_W_DEF = 8;
    localparam int IDX_W_DEF   = 16;

    // Wide enough to hold HW_K votes for a single class, so it can never wrap.
    function automatic int cnt_width(input int hw_k);
        return $clog2(hw_k + 1);
    endfunction

endpackage

// File: rtl/knn_label_hist.sv
// Per-class label histogram: synchronous clear, increment-by-label, out-of-range flag.
// Counts update one edge after inc; read port is combinational.
// No backpressure; accepts one label per cycle while inc is high.
module knn_label_hist
    import knn_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int LABEL_W   = LABEL_W_DEF,
    parameter int CNT_W     = 4,
    parameter int SEL_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [LABEL_W-1:0] label,
    output logic               oor,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_cnt
);

    logic [CNT_W-1:0] cnt [N_CLASSES];

    assign oor = inc && (label >= LABEL_W'(N_CLASSES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CLASSES; c++) begin
                if (clr) begin
                    cnt[c] <= '0;
                end else if (inc && (label == LABEL_W'(c))) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (rd_sel == SEL_W'(c)) begin
                rd_cnt = cnt[c];
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// k-NN majority vote: reads HW_K sorter slots, histograms labels, emits argmax class.
// Start-to-done latency HW_K+N_CLASSES edges; KNN_VOTE_NN_TIE_EN breaks ties toward slot 0.
// start is ignored while busy; no queueing, no downstream backpressure.
module knn_vote
    import knn_pkg::*;
#(
    parameter int HW_K      = 10,
    parameter int N_CLASSES = 10,
    parameter int LABEL_W   = LABEL_W_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IDX_W-1:0]   idx_out,
    input  logic [LABEL_W-1:0] label_in,
    output logic               busy,
    output logic               done,
    output logic [LABEL_W-1:0] class_out,
    output logic               err
);

    localparam int CNT_W = cnt_width(HW_K);
    localparam int SEL_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    state_t           state;
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] best;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             hist_clr;
    logic             hist_inc;
    logic             hist_oor;
    logic             last_slot;
    logic             last_class;
    logic             take;

    assign hist_clr   = (state == ST_IDLE) && start;
    assign hist_inc   = (state == ST_FETCH);
    assign last_slot  = (idx_out == IDX_W'(HW_K - 1));
    assign last_class = (scan_ptr == SEL_W'(N_CLASSES - 1));

`ifdef KNN_VOTE_NN_TIE_EN
    logic [LABEL_W-1:0] nn_label;

    // Strictly greater always wins; an equal count wins only for the nearest neighbour's class.
    assign take = (rd_cnt > best_cnt) ||
                  ((rd_cnt == best_cnt) && (LABEL_W'(scan_ptr) == nn_label));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nn_label <= '0;
        end else if ((state == ST_FETCH) && (idx_out == '0)) begin
            nn_label <= label_in;
        end
    end
`else
    assign take = (rd_cnt > best_cnt);
`endif

    knn_label_hist #(
        .N_CLASSES (N_CLASSES),
        .LABEL_W   (LABEL_W),
        .CNT_W     (CNT_W),
        .SEL_W     (SEL_W)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .clr    (hist_clr),
        .inc    (hist_inc),
        .label  (label_in),
        .oor    (hist_oor),
        .rd_sel (scan_ptr),
        .rd_cnt (rd_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx_out   <= '0;
            scan_ptr  <= '0;
            best      <= '0;
            best_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_out <= '0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err     <= 1'b0;
                        idx_out <= '0;
                        busy    <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (hist_oor) begin
                        err <= 1'b1;
                    end
                    if (last_slot) begin
                        idx_out  <= '0;
                        scan_ptr <= '0;
                        best     <= '0;
                        best_cnt <= '0;
                        state    <= ST_SCAN;
                    end else begin
                        idx_out <= idx_out + IDX_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (take) begin
                        best     <= scan_ptr;
                        best_cnt <= rd_cnt;
                    end
                    // The final comparison result is folded in directly rather than via best.
                    if (last_class) begin
                        class_out <= LABEL_W'(take ? scan_ptr : best);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        scan_ptr <= scan_ptr + SEL_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: vector table plus scoreboard, with reset/start corner cases.
// Honours KNN_VOTE_NN_TIE_EN for the tie expectation.
module tb_knn_vote;

    localparam int HW_K = 10;
    localparam int LAT  = 20;
    localparam int NV   = 9;

    typedef logic [0:9][7:0] slot_arr_t;

    typedef struct {
        slot_arr_t  lab;
        logic [7:0] cls;
        logic       e;
    } vec_t;

    typedef struct {
        logic [7:0] cls;
        logic       e;
        int         st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] idx_out;
    logic [7:0]  label_in;
    logic        busy;
    logic        done;
    logic [7:0]  class_out;
    logic        err;

    slot_arr_t slots;
    vec_t      vecs [NV];
    exp_t      sb [$];
    exp_t      m_e;
    int        cyc = 0;
    int        n_checks = 0;
    int        n_fail = 0;
    int        n_done = 0;

    knn_vote dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .idx_out   (idx_out),
        .label_in  (label_in),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sorter read port model: combinational lookup of the selected slot.
    always_comb begin
        label_in = 8'hff;
        for (int i = 0; i < HW_K; i++) begin
            if (idx_out == 16'(i)) label_in = slots[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("class_out", class_out, m_e.cls);
                check("err", err, m_e.e);
                check("latency", cyc - m_e.st, LAT);
                check("busy_in_done", busy, 0);
            end
        end
    end

    task automatic drive_start(input slot_arr_t s, input logic [7:0] c, input logic e, input bit push);
        exp_t x;
        slots = s;
        start = 1'b1;
        if (push) begin
            x.cls = c;
            x.e   = e;
            x.st  = cyc + 1;
            sb.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for_done(input int target, input string name);
        for (int i = 0; i < 60; i++) begin
            if (n_done >= target) break;
            @(negedge clk);
            #1;
        end
        check(name, (n_done >= target) ? 1 : 0, 1);
    endtask

    task automatic run_vote(input vec_t v, input string name);
        int n0;
        n0 = n_done;
        drive_start(v.lab, v.cls, v.e, 1'b1);
        wait_for_done(n0 + 1, name);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int n0;
        vec_t v;
        vecs[0] = '{lab: {8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7}, cls: 8'd3, e: 1'b0};
`ifdef KNN_VOTE_NN_TIE_EN
        vecs[1] = '{lab: {8'd5, 8'd2, 8'd5, 8'd2, 8'd2, 8'd5, 8'd9, 8'd8, 8'd7, 8'd6}, cls: 8'd5, e: 1'b0};
`else
        vecs[1] = '{lab: {8'd5, 8'd2, 8'd5, 8'd2, 8'd2, 8'd5, 8'd9, 8'd8, 8'd7, 8'd6}, cls: 8'd2, e: 1'b0};
`endif
        vecs[2] = '{lab: {8'd4, 8'd4, 8'd4, 8'd0, 8'd12, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5}, cls: 8'd4, e: 1'b1};
        vecs[3] = '{lab: {8'd1, 8'd7, 8'd1, 8'd7, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}, cls: 8'd1, e: 1'b0};
        vecs[4] = '{lab: {8'd0, 8'd3, 8'd3, 8'd8, 8'd8, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6}, cls: 8'd3, e: 1'b0};
        vecs[5] = '{lab: {8'd10, 8'd11, 8'd12, 8'd20, 8'd99, 8'd128, 8'd200, 8'd254, 8'd255, 8'd10}, cls: 8'd0, e: 1'b1};
        vecs[6] = '{lab: {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, cls: 8'd9, e: 1'b0};
        vecs[7] = '{lab: {8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd0}, cls: 8'd8, e: 1'b0};
        vecs[8] = '{lab: {8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6}, cls: 8'd6, e: 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        slots = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_idx_out", idx_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_class_out", class_out, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vote(vecs[i], "vote_timeout");
        end

        // err stays set after an out-of-range vote and clears at the next accepted start.
        run_vote(vecs[2], "oor_timeout");
        check("err_sticky_idle", err, 1);
        n0 = n_done;
        drive_start(vecs[0].lab, vecs[0].cls, vecs[0].e, 1'b1);
        check("err_cleared_on_start", err, 0);
        check("busy_after_start", busy, 1);
        for (int k = 0; k <= HW_K; k++) begin
            if (k > 0) @(negedge clk);
            check("idx_seq", idx_out, (k < HW_K) ? k : 0);
        end
        wait_for_done(n0 + 1, "readport_timeout");

        // start pulses mid-vote are ignored.
        @(negedge clk);
        n0 = n_done;
        drive_start(vecs[3].lab, vecs[3].cls, vecs[3].e, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_for_done(n0 + 1, "ignore_timeout");
        repeat (25) @(negedge clk);
        check("single_done", n_done - n0, 1);
        check("idle_after_ignore", busy, 0);

        // start held in the done cycle launches a second vote.
        n0 = n_done;
        drive_start(vecs[2].lab, vecs[2].cls, vecs[2].e, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        check("b2b_first_done", done, 1);
        v = vecs[7];
        drive_start(v.lab, v.cls, v.e, 1'b1);
        #1;
        check("b2b_busy", busy, 1);
        check("b2b_err_cleared", err, 0);
        wait_for_done(n0 + 2, "b2b_timeout");

        // Reset during FETCH aborts the vote with no done.
        repeat (3) @(negedge clk);
        n0 = n_done;
        v.lab = {8'd12, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        drive_start(v.lab, 8'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_err", err, 1);
        rst = 1'b0;
        #1;
        check("abort_idx_out", idx_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_class_out", class_out, 0);
        check("abort_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", n_done - n0, 0);
        run_vote(vecs[6], "post_rst_timeout");

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_done %0d expected completion", n_done);
        $fatal(1, "watchdog");
    end

endmodule
